// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage access controller. Takes one load or store from the MEM
//   stage, checks size/alignment, drives a single-beat memory request, waits
//   for mem_ready (bounded by TIMEOUT), and returns an extended load result.
//
// Parameters
//   TIMEOUT   max ACCESS cycles before the access is aborted (2..255)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_load, req_store  MEM stage holds a load / store
//   funct3               size and sign of the access
//   addr, wdata          byte address, right-justified store data
//   mem_en, mem_we       request strobe, write qualifier
//   mem_addr, mem_be     word address, byte enables
//   mem_wdata            lane-replicated store data
//   mem_ready, mem_rdata memory completion, read word
//   stall                freeze upstream stages
//   done, err            one-cycle completion / fault pulses
//   load_data            extended load result
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic        is_load_r;

  logic        any_req;
  logic        both_req;
  logic        f3_legal;
  logic        aligned;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Lane is shifted down to bit 0 first, then sign/zero extended.
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    sh  = rd >> {lane, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b001:  return 32'(h_s);
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  always_comb begin
    any_req  = req_load | req_store;
    both_req = req_load & req_store;
    f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Depends on live request inputs in IDLE, so it cannot be registered.
  assign stall = ((state == S_IDLE) && any_req) || (state == S_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      f3_r      <= 3'd0;
      lane_r    <= 2'd0;
      is_load_r <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (both_req) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else if (any_req) begin
            if (f3_legal && aligned) begin
              state     <= S_ACCESS;
              cnt       <= 8'd0;
              f3_r      <= funct3;
              lane_r    <= addr[1:0];
              is_load_r <= req_load;
              mem_en    <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= be_of(funct3, addr[1:0]);
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_of(funct3, wdata);
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // mem_ready takes priority over the timeout on the last cycle.
          if (mem_ready) begin
            state  <= S_DONE;
            done   <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
            if (is_load_r) load_data <= ext_load(f3_r, lane_r, mem_rdata);
          end else if (cnt == CNT_LAST) begin
            state  <= S_ERR;
            err    <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_load, req_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall, done, err;
  logic [31:0] load_data;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_load(req_load), .req_store(req_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall), .done(done),
    .load_data(load_data), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected per-cycle outputs, set by the transaction driver
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_en, exp_we, exp_done, exp_err;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, model_ld;

  // observations used by the literal pins
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  bit          en_seen;
  int          done_q[$];
  int          err_cyc, req_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: spec rules as plain arithmetic ----
  function automatic int m_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n = m_bytes(f3);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = m_bytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int     bits = 8 * m_bytes(f3);
    longint v;
    if (bits == 32) return rd;
    v = longint'(rd >> (8 * (a % 4))) % (longint'(1) << bits);
    if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("load_data", load_data, model_ld);
      if (exp_en) chk("mem_addr", mem_addr, exp_addr);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (mem_en) begin
      en_seen    = 1'b1;
      last_be    = mem_be;
      last_wdata = mem_wdata;
    end
    if (done) done_q.push_back(cyc);
    if (err) err_cyc = cyc;
  end

  task automatic set_idle();
    exp_stall = 0; exp_en = 0; exp_we = 0; exp_be = 0; exp_done = 0; exp_err = 0;
  endtask

  // One transaction. lat = ACCESS cycles with ready low before ready rises;
  // lat >= TO never raises ready. Returns at the IDLE cycle after DONE/ERR.
  task automatic txn(input bit ld, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int lat,
                     input logic [31:0] rd);
    bit timed = 1'b0;
    req_cyc   = cyc;
    req_load  = ld; req_store = st; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    set_idle();
    exp_stall = ld | st;
    step();
    // garbage on inputs while busy must not matter
    req_load = 0; req_store = 0; funct3 = 3'b111; addr = a ^ 32'hDEAD_BEE1; wdata = ~wd;
    if (!(ld && st) && m_legal(f3, a)) begin
      exp_en = 1; exp_we = st; exp_be = m_be(f3, a); exp_addr = a & ~32'h3;
      exp_wdata = m_wdata(f3, wd); exp_stall = 1;
      for (int i = 0; i < TO; i++) begin
        mem_ready = (i == lat);
        mem_rdata = (i == lat) ? rd : 32'h5A5A_5A5A;
        step();
        if (i == lat) break;
        if (i == TO - 1) timed = 1'b1;
      end
      exp_en = 0; exp_we = 0; exp_be = 0; exp_stall = 0;
      if (!timed) begin
        exp_done = 1;
        if (ld) model_ld = m_load(f3, a, rd);
      end else begin
        exp_err = 1;
      end
    end else begin
      exp_err = 1; exp_stall = 0;
    end
    mem_ready = 1'b1;   // ignored outside ACCESS
    step();
    mem_ready = 1'b0;
    set_idle();
  endtask

  initial begin
    rst_n = 1'b1; req_load = 0; req_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_ready = 0; mem_rdata = 0; model_ld = 0; en_seen = 0; err_cyc = 0; req_cyc = 0;
    set_idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // store word, ready after 2 cycles
    txn(0, 1, 3'b010, 32'h4, 32'hABCD_1234, 2, 0);
    chk("sw_be", {28'd0, last_be}, 32'hF);
    chk("sw_done_cnt", done_q.size(), 1);

    // load byte signed / unsigned at 0x7
    txn(1, 0, 3'b000, 32'h7, 0, 1, 32'h80FF_0000);
    chk("lb_be", {28'd0, last_be}, 32'h8);
    chk("lb_val", load_data, 32'hFFFF_FF80);
    txn(1, 0, 3'b100, 32'h7, 0, 0, 32'h80FF_0000);
    chk("lbu_val", load_data, 32'h0000_0080);

    // store half at 0xA, misaligned half at 0x9
    txn(0, 1, 3'b001, 32'hA, 32'h0000_BEEF, 0, 0);
    chk("sh_be", {28'd0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    en_seen = 0;
    txn(0, 1, 3'b001, 32'h9, 32'h0000_BEEF, 0, 0);
    chk("sh_mis_no_en", {31'd0, en_seen}, 32'd0);

    // more load shapes and an illegal funct3
    txn(1, 0, 3'b001, 32'h2, 0, 3, 32'h8001_1234);
    chk("lh_val", load_data, 32'hFFFF_8001);
    txn(1, 0, 3'b101, 32'h2, 0, 0, 32'h8001_1234);
    txn(1, 0, 3'b010, 32'hC, 0, 0, 32'h1357_9BDF);
    txn(1, 0, 3'b010, 32'h6, 0, 0, 32'h1111_1111);
    en_seen = 0;
    txn(1, 0, 3'b011, 32'h0, 0, 0, 32'h2222_2222);
    chk("bad_f3_no_en", {31'd0, en_seen}, 32'd0);
    txn(0, 1, 3'b000, 32'h1, 32'h0000_00A5, 1, 0);

    // timeout: err 17 cycles after the request, load_data unchanged
    txn(1, 0, 3'b010, 32'h20, 0, 1000, 32'hFFFF_FFFF);
    chk("to_err_cycle", err_cyc - req_cyc, 17);
    chk("to_ld_kept", load_data, 32'h1357_9BDF);
    // ready on the final allowed cycle wins
    txn(1, 0, 3'b010, 32'h24, 0, TO - 1, 32'hCAFE_F00D);
    chk("to_edge_ld", load_data, 32'hCAFE_F00D);

    // both requests, then back-to-back loads
    txn(1, 1, 3'b010, 32'h4, 0, 0, 0);
    txn(1, 0, 3'b010, 32'h4, 0, 0, 32'h0404_0404);
    txn(1, 0, 3'b010, 32'h8, 0, 0, 32'h0808_0808);
    chk("b2b_gap", done_q[$] - done_q[$-1], 3);

    // reset in ACCESS cycle 2
    chk_en = 1'b0;
    req_load = 1; funct3 = 3'b010; addr = 32'h10;
    step();
    req_load = 0;
    step();
    #2;
    chk("mid_en_before", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_en", {31'd0, mem_en}, 32'd0);
    chk("mid_be_addr", {28'd0, mem_be} | mem_addr, 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_ld", load_data, 32'd0);
    chk("mid_stall", {29'd0, stall, done, err}, 32'd0);
    model_ld = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    set_idle();
    chk_en = 1'b1;
    txn(1, 0, 3'b010, 32'h8, 0, 1, 32'h8888_0001);
    chk("post_rst_ld", load_data, 32'h8888_0001);

    // idle with stray mem_ready
    mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles before the access is aborted (legal range 2..255).
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have req_load  input  1  MEM stage holds a load instruction (OPCODE_LOAD).
REQ-005 SHALL have req_store  input  1  MEM stage holds a store instruction (OPCODE_STORE).
REQ-006 SHALL have funct3  input  3  size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 SHALL have addr  input  32  byte address (alu_result).
REQ-008 SHALL have wdata  input  32  store data (rs2_data), right-justified.
REQ-009 SHALL have mem_en, mem_we  output  1 each  memory request strobe and write qualifier.
REQ-010 SHALL have mem_addr  output  32  word address: addr[31:2] with bits [1:0] forced to 00.
REQ-011 SHALL have mem_be  output  4  byte enables; mem_wdata  output  32  lane-shifted store data.
REQ-012 SHALL have mem_ready  input  1 and mem_rdata  input  32  memory completion and read word.
REQ-013 SHALL have stall  output  1  freeze upstream stages; done  output  1  one-cycle completion pulse.
REQ-014 SHALL have load_data  output  32  extended load result (LMD); err  output  1  one-cycle fault pulse.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DONE, ERR.
REQ-016 IDLE, exactly one of req_load/req_store high, legal funct3, aligned -> capture addr/wdata/funct3/type, go ACCESS.
REQ-017 Alignment: half needs addr[0]=0; word needs addr[1:0]=00; a violation or an illegal funct3 (011, 110, 111) -> ERR with no memory access.
REQ-018 req_load and req_store both high in IDLE -> ERR.
REQ-019 ACCESS: mem_en=1, mem_we=1 only for stores, outputs driven from the captured registers, stable until mem_ready.
REQ-020 ACCESS with mem_ready=1 -> DONE; a load registers the extended mem_rdata into load_data on that edge.
REQ-021 ACCESS: an 8-bit cycle counter increments each cycle; counter = TIMEOUT-1 with no mem_ready -> ERR; mem_ready on that same cycle wins (-> DONE).
REQ-022 DONE: done=1 for one cycle, then IDLE; ERR: err=1 for one cycle, then IDLE; load_data is unchanged on ERR.
REQ-023 stall = (req_load|req_store) in IDLE, or state=ACCESS; stall=0 in DONE and ERR so the pipeline advances.
REQ-024 Byte enables: byte -> 0001 << addr[1:0]; half -> 0011 << addr[1:0]; word -> 1111; mem_be=0000 when mem_en=0.
REQ-025 mem_wdata: byte replicated into all four lanes; half replicated into both halves; word passed through.
REQ-026 load_data: selected lane sign-extended (000, 001) or zero-extended (100, 101) to 32 bits; word passed through.
REQ-027 Inputs are ignored outside IDLE; a new request is sampled only in IDLE, so there is a minimum 3-cycle spacing (IDLE, ACCESS, DONE).
REQ-028 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counter 0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, done=0, err=0.
REQ-030 Reset asserted during ACCESS SHALL drop mem_en asynchronously and discard the access; after release the block is in IDLE and stall follows REQ-023.

Verification
REQ-031 Store word: addr=0x4, wdata=0xABCD1234, ready after 2 cycles -> mem_addr=0x4, be=1111, stall until DONE, done pulse once.
REQ-032 Load byte signed: addr=0x7, mem_rdata=0x80FF_0000 -> be=1000, load_data=0xFFFFFF80; funct3=100 gives 0x00000080.
REQ-033 Store half at addr=0xA, wdata=0x0000BEEF -> be=1100, mem_wdata=0xBEEFBEEF; a half at addr=0x9 -> err pulse, mem_en never high.
REQ-034 Timeout: TIMEOUT=16 and mem_ready held low -> err on the 17th cycle after the request, stall released in the ERR cycle, load_data unchanged.
REQ-035 Reset mid-access: rst_n low in ACCESS cycle 2 -> mem_en=0 the same time step, all outputs 0; a following load of addr=0x8 completes normally.
REQ-036 Both request inputs high -> err pulse; back-to-back loads at addr 0x4 then 0x8 -> two done pulses 3 cycles apart.
